// File: rtl/exhaustive_truth_checker.sv
// Exhaustive truth-table engine: sweeps every input vector into an external
// combinational circuit and either checks its response against a golden table or captures it.
module exhaustive_truth_checker #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [(1<<N_IN)-1:0]   golden,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   equal,
    output logic [N_IN:0]          mismatch_count,
    output logic [N_IN:0]          ones_count,
    output logic [N_IN-1:0]        first_fail,
    output logic                   fail_valid,
    output logic [(1<<N_IN)-1:0]   tt_out
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [(1<<N_IN)-1:0] golden_q, golden_d;
    logic                 mode_q, mode_d;
    logic [CW-1:0]        settle_q, settle_d;
    logic [N_IN-1:0]      stim_q, stim_d;
    logic [N_IN:0]        mism_q, mism_d;
    logic [N_IN:0]        ones_q, ones_d;
    logic [N_IN-1:0]      ffail_q, ffail_d;
    logic                 fvalid_q, fvalid_d;
    logic                 equal_q, equal_d;
    logic [(1<<N_IN)-1:0] tt_q, tt_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DRIVE;
            S_DRIVE:  if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (stim_q == '1) ? S_DONE : S_DRIVE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_DRIVE, S_SAMPLE: busy = 1'b1;
            S_DONE:            done = 1'b1;
            default:           ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        golden_d = golden_q;
        mode_d   = mode_q;
        settle_d = settle_q;
        stim_d   = stim_q;
        mism_d   = mism_q;
        ones_d   = ones_q;
        ffail_d  = ffail_q;
        fvalid_d = fvalid_q;
        equal_d  = equal_q;
        tt_d     = tt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    golden_d = golden;
                    mode_d   = mode;
                    settle_d = '0;
                    stim_d   = '0;
                    mism_d   = '0;
                    ones_d   = '0;
                    ffail_d  = '0;
                    fvalid_d = 1'b0;
                    equal_d  = 1'b0;
                    tt_d     = '0;
                end
            end
            S_DRIVE: begin
                if (settle_q != SETTLE_LAST) settle_d = settle_q + 1'b1;
            end
            S_SAMPLE: begin
                ones_d = ones_q + (N_IN+1)'(dut_out);
                if (!mode_q) begin
                    if (dut_out != golden_q[stim_q]) begin
                        mism_d = mism_q + 1'b1;
                        if (!fvalid_q) begin
                            ffail_d  = stim_q;
                            fvalid_d = 1'b1;
                        end
                    end
                end else begin
                    tt_d[stim_q] = dut_out;
                end
                // Last vector keeps stim parked so it reads back as the final index
                if (stim_q != '1) begin
                    stim_d   = stim_q + 1'b1;
                    settle_d = '0;
                end
            end
            S_DONE: begin
                equal_d = !mode_q && (mism_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            golden_q <= '0;
            mode_q   <= 1'b0;
            settle_q <= '0;
            stim_q   <= '0;
            mism_q   <= '0;
            ones_q   <= '0;
            ffail_q  <= '0;
            fvalid_q <= 1'b0;
            equal_q  <= 1'b0;
            tt_q     <= '0;
        end else begin
            golden_q <= golden_d;
            mode_q   <= mode_d;
            settle_q <= settle_d;
            stim_q   <= stim_d;
            mism_q   <= mism_d;
            ones_q   <= ones_d;
            ffail_q  <= ffail_d;
            fvalid_q <= fvalid_d;
            equal_q  <= equal_d;
            tt_q     <= tt_d;
        end
    end

    assign stim           = stim_q;
    assign mismatch_count = mism_q;
    assign ones_count     = ones_q;
    assign first_fail     = ffail_q;
    assign fail_valid     = fvalid_q;
    assign equal          = equal_q;
    assign tt_out         = tt_q;

endmodule

// File: tb/tb_exhaustive_truth_checker.sv
// Directed bench for exhaustive_truth_checker: one SETTLE=1 instance with
// selectable circuit models and one SETTLE=3 instance driving a delayed circuit.
module tb_exhaustive_truth_checker;

    logic        clk = 1'b0;
    logic        reset, start, start1, mode;
    logic [15:0] golden;
    int          sel0;

    logic        dut_out0, dut_out1;
    logic [3:0]  stim0, stim1, ff0, ff1;
    logic        busy0, busy1, done0, done1, eq0, eq1, fv0, fv1;
    logic [4:0]  mm0, mm1, ones0, ones1;
    logic [15:0] tt0, tt1;

    logic        d0_r1, d0_r2, d1_r1, d1_r2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Circuit models: parity, A&B, parity behind two register stages
    always @(posedge clk) begin
        d0_r1 <= ^stim0;
        d0_r2 <= d0_r1;
        d1_r1 <= ^stim1;
        d1_r2 <= d1_r1;
    end
    assign dut_out0 = (sel0 == 0) ? ^stim0 : (sel0 == 1) ? (stim0[3] & stim0[2]) : d0_r2;
    assign dut_out1 = d1_r2;

    exhaustive_truth_checker #(.N_IN(4), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .golden(golden),
        .dut_out(dut_out0), .stim(stim0), .busy(busy0), .done(done0), .equal(eq0),
        .mismatch_count(mm0), .ones_count(ones0), .first_fail(ff0),
        .fail_valid(fv0), .tt_out(tt0)
    );

    exhaustive_truth_checker #(.N_IN(4), .SETTLE(3)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .golden(golden),
        .dut_out(dut_out1), .stim(stim1), .busy(busy1), .done(done1), .equal(eq1),
        .mismatch_count(mm1), .ones_count(ones1), .first_fail(ff1),
        .fail_valid(fv1), .tt_out(tt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on u0; cyc = cycles from the accepting edge until done is seen
    task automatic sweep0(output int cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic sweep1(output int cyc);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int dones, done_idx;
    logic busy33;
    logic busy_early;

    initial begin
        reset = 1'b1; start = 1'b0; start1 = 1'b0; mode = 1'b0;
        golden = 16'h6996; sel0 = 0;
        repeat (3) @(negedge clk);

        chk("rst_stim",  32'(stim0), 0);
        chk("rst_busy",  32'(busy0), 0);
        chk("rst_done",  32'(done0), 0);
        chk("rst_mm",    32'(mm0), 0);
        chk("rst_tt",    32'(tt0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        reset = 1'b0;

        // Parity circuit against the matching golden table
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_early = busy0;
        cyc = 0;
        while (!done0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_after_start", 32'(busy_early), 1);
        chk("lat_parity", cyc, 32);
        chk("busy_in_done", 32'(busy0), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done0), 0);
        chk("eq_parity", 32'(eq0), 1);
        chk("mm_parity", 32'(mm0), 0);
        chk("ones_parity", 32'(ones0), 8);
        chk("fv_parity", 32'(fv0), 0);
        chk("stim_final", 32'(stim0), 15);

        // Bit 0 flipped in golden
        golden = 16'h6997;
        sweep0(cyc);
        @(negedge clk);
        chk("mm_b0", 32'(mm0), 1);
        chk("ff_b0", 32'(ff0), 0);
        chk("fv_b0", 32'(fv0), 1);
        chk("eq_b0", 32'(eq0), 0);

        // Bit 15 flipped in golden
        golden = 16'hE996;
        sweep0(cyc);
        @(negedge clk);
        chk("mm_b15", 32'(mm0), 1);
        chk("ff_b15", 32'(ff0), 15);
        chk("fv_b15", 32'(fv0), 1);
        chk("eq_b15", 32'(eq0), 0);
        chk("ones_b15", 32'(ones0), 8);

        // Learn mode with A & B
        sel0 = 1; mode = 1'b1;
        sweep0(cyc);
        @(negedge clk);
        chk("tt_learn", 32'(tt0), 32'hF000);
        chk("ones_learn", 32'(ones0), 4);
        chk("eq_learn", 32'(eq0), 0);
        chk("mm_learn", 32'(mm0), 0);

        // Two-cycle delayed circuit: SETTLE=3 absorbs it, SETTLE=1 does not
        mode = 1'b0; golden = 16'h6996;
        sweep1(cyc);
        chk("lat_settle3", cyc, 64);
        @(negedge clk);
        chk("eq_settle3", 32'(eq1), 1);
        chk("mm_settle3", 32'(mm1), 0);
        chk("ones_settle3", 32'(ones1), 8);
        sel0 = 2;
        sweep0(cyc);
        @(negedge clk);
        chk("mm_settle1_delay_nz", 32'(mm0 != 0), 1);
        chk("eq_settle1_delay", 32'(eq0), 0);

        // Reset at cycle 10 of a sweep
        sel0 = 0; golden = 16'h6997;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_stim", 32'(stim0), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_done", 32'(done0), 0);
        chk("mid_rst_eq",   32'(eq0), 0);
        chk("mid_rst_mm",   32'(mm0), 0);
        chk("mid_rst_ones", 32'(ones0), 0);
        chk("mid_rst_ff",   32'(ff0), 0);
        chk("mid_rst_fv",   32'(fv0), 0);
        chk("mid_rst_tt",   32'(tt0), 0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        sweep0(cyc);
        chk("post_rst_lat", cyc, 32);
        @(negedge clk);
        chk("post_rst_mm", 32'(mm0), 1);
        chk("post_rst_ff", 32'(ff0), 0);
        chk("post_rst_ones", 32'(ones0), 8);

        // Starts during a sweep and in the done cycle, plus golden/mode changes, are ignored
        golden = 16'h6996; mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        dones = 0; done_idx = -1; busy33 = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            start = (i == 5) || (i == 20);
            if (i == 10) begin
                golden = 16'h0000;
                mode   = 1'b1;
            end
            if (done0) begin
                dones++;
                done_idx = i;
                start = 1'b1;
            end
            if (i == 33) busy33 = busy0;
        end
        start = 1'b0;
        chk("ign_done_count", dones, 1);
        chk("ign_done_idx", done_idx, 32);
        chk("ign_start_in_done", 32'(busy33), 0);
        chk("ign_eq", 32'(eq0), 1);
        chk("ign_mm", 32'(mm0), 0);
        chk("ign_ones", 32'(ones0), 8);
        chk("ign_tt", 32'(tt0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
